// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI byte-engine scheduler.
// Requester index map: ZX=0, AVR=1, DMA=2.
package spi_sched_pkg;

  localparam int NREQ_DEF     = 3;
  localparam int BYTE_CYC_DEF = 18;
  localparam int CNT_W_DEF    = 5;
  localparam int IDX_W        = 2;

  localparam int REQ_ZX  = 0;
  localparam int REQ_AVR = 1;
  localparam int REQ_DMA = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Round-robin pointer advance: the slot after the winner, wrapping at nreq.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int nreq);
    if (int'(idx) >= nreq - 1) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/spi_sched_if.sv
// Requester-side bus of the scheduler: per-requester request/CS/data in,
// per-requester ack plus shared read data and ownership status out.
interface spi_sched_if #(parameter int NREQ = spi_sched_pkg::NREQ_DEF) ();

  logic [NREQ-1:0]                   req;
  logic [NREQ-1:0]                   req_cs_n;
  logic [8*NREQ-1:0]                 req_data;
  logic [NREQ-1:0]                   ack;
  logic [7:0]                        rdata;
  logic [spi_sched_pkg::IDX_W-1:0]   owner;
  logic                              owned;
  logic                              busy;

  modport slave (
    input  req, req_cs_n, req_data,
    output ack, rdata, owner, owned, busy
  );

  modport master (
    output req, req_cs_n, req_data,
    input  ack, rdata, owner, owned, busy
  );

endinterface

// File: rtl/spi_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first claimant at or after ptr wins,
// reported as a one-hot grant and as an index.
module rr_arbiter import spi_sched_pkg::*; #(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  claim,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Scan claimants starting at the pointer; the first hit is latched into gnt/idx.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    idx     = {IDX_W{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDX_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found_s && claim[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/spi_sched.sv
// Shares one spi2 byte engine and the SD card CS_n between requesters:
// CS-based ownership lock, round-robin grant, fixed-length byte sequencing.
module spi_sched import spi_sched_pkg::*; #(
  parameter int NREQ     = NREQ_DEF,
  parameter int BYTE_CYC = BYTE_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        fclk,
  input  logic        rst,
  spi_sched_if.slave  bus,
  output logic        sdcs_n,
  output logic        spi_start,
  output logic [7:0]  spi_din,
  input  logic [7:0]  spi_dout
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owned_q, owned_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             busy_q, busy_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             sdcs_n_q, sdcs_n_d;
  logic             spi_start_q, spi_start_d;
  logic [7:0]       spi_din_q, spi_din_d;

  logic [NREQ-1:0]  claim_s;
  logic [NREQ-1:0]  gnt_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             cur_req_s;
  logic             cur_cs_n_s;

  assign claim_s    = bus.req | ~bus.req_cs_n;
  assign cur_req_s  = bus.req[owner_q];
  assign cur_cs_n_s = bus.req_cs_n[owner_q];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .claim (claim_s),
    .ptr   (rr_q),
    .gnt   (gnt_s),
    .idx   (gnt_idx_s)
  );

  // Next-state logic: ownership, CS tracking and the byte sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owned_d     = owned_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    busy_d      = busy_q;
    ack_d       = {NREQ{1'b0}};
    rdata_d     = rdata_q;
    spi_start_d = 1'b0;
    spi_din_d   = spi_din_q;

    // CS follows the owner but is frozen while a byte is on the wire.
    if (owned_q && !busy_q) begin
      sdcs_n_d = cur_cs_n_s;
    end else begin
      sdcs_n_d = sdcs_n_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!owned_q) begin
          if (|gnt_s) begin
            owned_d = 1'b1;
            owner_d = gnt_idx_s;
            rr_d    = rr_next(gnt_idx_s, NREQ);
          end else begin
            owned_d = 1'b0;
          end
        end else if (cur_req_s) begin
          state_d     = ST_START;
          spi_din_d   = bus.req_data[{owner_q, 3'b000} +: 8];
          spi_start_d = 1'b1;
          busy_d      = 1'b1;
        end else if (cur_cs_n_s) begin
          owned_d  = 1'b0;
          sdcs_n_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_d   = CNT_W'(BYTE_CYC - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d        = ST_DONE;
          ack_d[owner_q] = 1'b1;
          rdata_d        = spi_dout;
          busy_d         = 1'b0;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      owned_q     <= 1'b0;
      owner_q     <= {IDX_W{1'b0}};
      rr_q        <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      ack_q       <= {NREQ{1'b0}};
      rdata_q     <= 8'h00;
      sdcs_n_q    <= 1'b1;
      spi_start_q <= 1'b0;
      spi_din_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owned_q     <= owned_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      sdcs_n_q    <= sdcs_n_d;
      spi_start_q <= spi_start_d;
      spi_din_q   <= spi_din_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.owner = owner_q;
  assign bus.owned = owned_q;
  assign bus.busy  = busy_q;
  assign sdcs_n    = sdcs_n_q;
  assign spi_start = spi_start_q;
  assign spi_din   = spi_din_q;

endmodule

// File: tb/tb_spi_sched.sv
// Self-checking bench for spi_sched: spi2 model returns tx^8'h99 after BYTE_CYC,
// per-requester scoreboard queues checked on every ack pulse.
module tb_spi_sched;
  import spi_sched_pkg::*;

  localparam int NREQ     = 3;
  localparam int BYTE_CYC = 18;

  logic       fclk = 1'b0;
  logic       rst;
  logic       sdcs_n;
  logic       spi_start;
  logic [7:0] spi_din;
  logic [7:0] spi_dout;

  spi_sched_if #(.NREQ(NREQ)) bus ();

  spi_sched #(.NREQ(NREQ), .BYTE_CYC(BYTE_CYC), .CNT_W(5)) dut (
    .fclk      (fclk),
    .rst       (rst),
    .bus       (bus),
    .sdcs_n    (sdcs_n),
    .spi_start (spi_start),
    .spi_din   (spi_din),
    .spi_dout  (spi_dout)
  );

  always #5 fclk = ~fclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // spi2 model: junk until BYTE_CYC cycles after the start strobe, then tx ^ 8'h99.
  logic [7:0] cap_q;
  int         mcnt_q;
  always @(posedge fclk or posedge rst) begin
    if (rst) begin
      mcnt_q   <= 0;
      cap_q    <= 8'h00;
      spi_dout <= 8'h00;
    end else if (spi_start) begin
      cap_q    <= spi_din;
      mcnt_q   <= BYTE_CYC - 1;
      spi_dout <= 8'h00;
    end else if (mcnt_q > 0) begin
      mcnt_q <= mcnt_q - 1;
      if (mcnt_q == 1) spi_dout <= cap_q ^ 8'h99;
    end
  end

  logic [7:0] exp_q [NREQ][$];
  int         n_acks [NREQ] = '{default: 0};
  int         n_starts = 0;
  int         cyc_cnt  = 0;
  int         start_cyc = 0;
  logic [7:0] start_din = 8'h00;
  logic       prev_start = 1'b0;

  // Output monitor: start strobe shape, data stability, ack scoreboard and latency.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge fclk);
      if (!rst) begin
        cyc_cnt++;
        if (spi_start) begin
          check("start_single", prev_start, 1'b0);
          check("start_busy", bus.busy, 1'b1);
          n_starts++;
          start_cyc = cyc_cnt;
          start_din = spi_din;
        end else if (bus.busy) begin
          check("din_stable", spi_din, start_din);
        end
        prev_start = spi_start;
        if (bus.ack != 3'b000) begin
          check("ack_onehot", $countones(bus.ack), 1);
          for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
              n_acks[i]++;
              if (exp_q[i].size() == 0) begin
                check("ack_unexpected", i, 99);
              end else begin
                e = exp_q[i].pop_front();
                check("rdata", bus.rdata, e ^ 8'h99);
                check("spi_din", start_din, e);
                check("ack_latency", cyc_cnt - start_cyc, BYTE_CYC + 1);
              end
            end
          end
        end
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic wait_ack(input int i, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(negedge fclk);
      cyc++;
      seen = bus.ack[i];
    end
    check("ack_seen", seen, 1'b1);
  endtask

  task automatic drive(input int i, input logic r, input logic cs_n, input logic [7:0] d);
    bus.req[i]             = r;
    bus.req_cs_n[i]        = cs_n;
    bus.req_data[8*i +: 8] = d;
  endtask

  int c;
  int base_s;
  int base_a;

  initial begin
    rst          = 1'b1;
    bus.req      = 3'b000;
    bus.req_cs_n = 3'b111;
    bus.req_data = 24'h000000;
    tick(2);
    check("rst_owned", bus.owned, 1'b0);
    check("rst_owner", bus.owner, 2'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ack", bus.ack, 3'b000);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_sdcs_n", sdcs_n, 1'b1);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_spi_din", spi_din, 8'h00);
    rst = 1'b0;
    tick(1);

    // single byte from requester 0
    drive(0, 1'b1, 1'b0, 8'hA5);
    exp_q[0].push_back(8'hA5);
    wait_ack(0, c);
    check("t1_latency", c, BYTE_CYC + 3);
    check("t1_sdcs_n", sdcs_n, 1'b0);
    check("t1_rdata", bus.rdata, 8'h3C);
    drive(0, 1'b0, 1'b1, 8'hA5);
    tick(3);
    check("t1_rel_owned", bus.owned, 1'b0);
    check("t1_rel_sdcs_n", sdcs_n, 1'b1);

    // simultaneous claims from 1 and 2
    drive(1, 1'b1, 1'b0, 8'h5A);
    drive(2, 1'b1, 1'b0, 8'hC3);
    exp_q[1].push_back(8'h5A);
    exp_q[2].push_back(8'hC3);
    tick(2);
    check("t2_owned", bus.owned, 1'b1);
    check("t2_owner1", bus.owner, 2'd1);
    wait_ack(1, c);
    check("t2_order", n_acks[2], 0);
    drive(1, 1'b0, 1'b1, 8'h5A);
    wait_ack(2, c);
    check("t2_owner2", bus.owner, 2'd2);
    drive(2, 1'b0, 1'b1, 8'hC3);
    tick(3);
    check("t2_rel_owned", bus.owned, 1'b0);

    // multi-byte CS lock by requester 0 with requester 1 pending
    base_a = n_acks[1];
    drive(0, 1'b1, 1'b0, 8'h10);
    exp_q[0].push_back(8'h10);
    drive(1, 1'b1, 1'b0, 8'hE1);
    exp_q[1].push_back(8'hE1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        drive(0, 1'b1, 1'b0, 8'(8'h10 + k));
        exp_q[0].push_back(8'(8'h10 + k));
      end
      wait_ack(0, c);
      check("t3_owner", bus.owner, 2'd0);
      bus.req[0] = 1'b0;
      tick(3);
      check("t3_sdcs_n", sdcs_n, 1'b0);
      check("t3_owned", bus.owned, 1'b1);
      check("t3_pending", n_acks[1], base_a);
    end
    bus.req_cs_n[0] = 1'b1;
    wait_ack(1, c);
    check("t3_owner1", bus.owner, 2'd1);
    drive(1, 1'b0, 1'b1, 8'hE1);
    tick(3);

    // CS raised and req dropped mid-transfer
    drive(0, 1'b1, 1'b0, 8'h77);
    exp_q[0].push_back(8'h77);
    tick(10);
    check("t4_busy", bus.busy, 1'b1);
    drive(0, 1'b0, 1'b1, 8'h77);
    tick(1);
    check("t4_hold", sdcs_n, 1'b0);
    wait_ack(0, c);
    check("t4_hold_done", sdcs_n, 1'b0);
    tick(1);
    check("t4_sdcs_n", sdcs_n, 1'b1);
    tick(2);
    check("t4_owned", bus.owned, 1'b0);

    // reset during WAIT
    drive(1, 1'b1, 1'b0, 8'h11);
    exp_q[1].push_back(8'h11);
    tick(10);
    check("t5_busy", bus.busy, 1'b1);
    base_a = n_acks[1];
    rst = 1'b1;
    #1;
    check("t5_sdcs_n", sdcs_n, 1'b1);
    check("t5_busy0", bus.busy, 1'b0);
    check("t5_spi_start", spi_start, 1'b0);
    check("t5_owned", bus.owned, 1'b0);
    check("t5_ack", bus.ack, 3'b000);
    exp_q[1].delete();
    drive(1, 1'b0, 1'b1, 8'h11);
    tick(1);
    rst = 1'b0;
    tick(25);
    check("t5_noack", n_acks[1], base_a);

    // back-to-back bytes with req held
    base_s = n_starts;
    base_a = n_acks[2];
    drive(2, 1'b1, 1'b0, 8'h42);
    exp_q[2].push_back(8'h42);
    for (int k = 0; k < 3; k++) begin
      wait_ack(2, c);
      if (k > 0) check("t6_gap", c, BYTE_CYC + 3);
      if (k < 2) begin
        bus.req_data[23:16] = 8'(8'h43 + k);
        exp_q[2].push_back(8'(8'h43 + k));
      end else begin
        drive(2, 1'b0, 1'b1, 8'h00);
      end
    end
    tick(25);
    check("t6_starts", n_starts - base_s, 3);
    check("t6_acks", n_acks[2] - base_a, 3);
    for (int i = 0; i < NREQ; i++) check("sb_empty", exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
